// File: rtl/tx_handshake.sv
// tx_handshake: hands packets from the router core (clk domain) to the
// serial transmitter using a 4-phase TX_Data_Valid/TX_Data_Ack handshake.
// Packets are queued in a small circular buffer; TX_Data_Ack comes from
// another clock domain and is synchronised into clk before the FSM uses it.
//
// Ports
//   clk, rst_n     core clock, asynchronous active-low reset
//   rc_data        packet offered by the router core
//   rc_has_data    router core offers rc_data this cycle
//   tx_ready       buffer can take a packet this cycle
//   TX_Data        packet presented to the transmitter
//   TX_Data_Valid  registered request to the transmitter
//   TX_Data_Ack    transmitter acknowledge (asynchronous to clk)
//   tx_count       packets buffered, excluding the one already in TX_Data
//   fsm_state      handshake FSM state for debug (RST=0 IDLE=1 REQ=2 RELEASE=3)
//
// Handshakes
//   Core side: a packet is accepted on a rising clk edge where
//   rc_has_data && tx_ready; while not accepted the core holds rc_data and
//   rc_has_data. Transmitter side (4-phase): Valid rises with TX_Data
//   stable, transmitter raises Ack, Valid falls, transmitter drops Ack,
//   and only then may the next Valid rise.
module tx_handshake #(
  parameter int WIDTH       = 55,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           rc_data,
  input  logic                       rc_has_data,
  output logic                       tx_ready,
  output logic [WIDTH-1:0]           TX_Data,
  output logic                       TX_Data_Valid,
  input  logic                       TX_Data_Ack,
  output logic [$clog2(DEPTH+1)-1:0] tx_count,
  output logic [1:0]                 fsm_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    RST     = 2'd0,
    IDLE    = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   ack_s;
  logic                   sync_ok;
  logic                   push;
  logic                   pop;
  state_t                 state;
  state_t                 state_n;

  // Ack synchroniser. fill_q marks when the synchroniser has been
  // sampling the live Ack long enough for ack_s to be trusted; without it
  // the zeroed synchroniser would let RST exit while the transmitter is
  // still holding Ack from before the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], TX_Data_Ack};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign sync_ok = fill_q[SYNC_STAGES-1];

  assign tx_ready  = (count != CW'(DEPTH)) && (state != RST);
  assign push      = rc_has_data && tx_ready;
  assign tx_count  = count;
  assign fsm_state = state;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      RST: begin
        if (sync_ok && !ack_s) state_n = IDLE;
      end
      IDLE: begin
        // Ack is deliberately ignored here: an Ack edge in IDLE is a
        // transmitter protocol violation and must not move the FSM.
        if (count != '0) begin
          pop     = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack_s) state_n = RELEASE;
      end
      RELEASE: begin
        if (!ack_s) state_n = IDLE;
      end
      default: state_n = RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RST;
      TX_Data_Valid <= 1'b0;
      TX_Data       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      state         <= state_n;
      TX_Data_Valid <= (state_n == REQ);
      if (pop) begin
        TX_Data <= mem[rd_ptr];
        rd_ptr  <= bump(rd_ptr);
      end
      if (push) wr_ptr <= bump(wr_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rc_data;
  end

endmodule
